// File: rtl/fft_frame_loader.sv
// Serial-to-parallel frame assembler feeding the 8-point FFT core.
// A fill bank collects samples while the output bank holds the frame offered to the FFT.
module fft_frame_loader #(
  parameter int N  = 8,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  input  logic            s_last,
  output logic            frame_valid,
  input  logic            frame_ready,
  output logic [N*DW-1:0] frame_data,
  output logic            short_frame,
  output logic [CW-1:0]   frame_cnt
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic signed [DW-1:0] fill_p0   [N];
  logic signed [DW-1:0] closed_p0 [N];
  logic signed [DW-1:0] out_p1    [N];
  logic [IW-1:0]        idx_p0;
  logic                 fill_full;
  logic                 short_pend;
  logic                 vld_p1;
  logic                 accept;
  logic                 close;
  logic                 is_short;
  logic                 slot_free;
  logic                 handoff;

  assign s_ready     = !fill_full;
  assign accept      = s_valid && !fill_full;
  assign close       = accept && ((idx_p0 == LAST_IDX) || s_last);
  assign is_short    = (idx_p0 != LAST_IDX);
  assign slot_free   = !vld_p1 || frame_ready;
  assign handoff     = vld_p1 && frame_ready;
  assign frame_valid = vld_p1;

  // Stage p0: the frame as it would look if closed by the sample on s_data now
  always_comb begin
    for (int k = 0; k < N; k++) begin
      closed_p0[k] = fill_p0[k];
      if (k == int'(idx_p0))
        closed_p0[k] = signed'(s_data);
      else if (k > int'(idx_p0))
        closed_p0[k] = '0;
    end
  end

  always_comb begin
    frame_data = '0;
    for (int k = 0; k < N; k++)
      frame_data[k*DW +: DW] = out_p1[k];
  end

  // Stage p1: output bank, handshake state and frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        fill_p0[k] <= '0;
        out_p1[k]  <= '0;
      end
      idx_p0      <= '0;
      fill_full   <= 1'b0;
      short_pend  <= 1'b0;
      vld_p1      <= 1'b0;
      short_frame <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      short_frame <= 1'b0;
      if (handoff)
        frame_cnt <= frame_cnt + CW'(1);

      if (fill_full) begin
        // A completed frame is parked in the fill bank; it moves out on the next consume
        if (handoff) begin
          for (int k = 0; k < N; k++) begin
            out_p1[k]  <= fill_p0[k];
            fill_p0[k] <= '0;
          end
          fill_full   <= 1'b0;
          idx_p0      <= '0;
          short_frame <= short_pend;
        end
      end else if (close) begin
        idx_p0 <= '0;
        if (slot_free) begin
          for (int k = 0; k < N; k++) begin
            out_p1[k]  <= closed_p0[k];
            fill_p0[k] <= '0;
          end
          vld_p1      <= 1'b1;
          short_frame <= is_short;
        end else begin
          for (int k = 0; k < N; k++)
            fill_p0[k] <= closed_p0[k];
          fill_full  <= 1'b1;
          short_pend <= is_short;
        end
      end else begin
        if (accept) begin
          fill_p0[idx_p0] <= signed'(s_data);
          idx_p0          <= idx_p0 + IW'(1);
        end
        if (handoff)
          vld_p1 <= 1'b0;
      end
    end
  end

endmodule
